// File: rtl/nios2core_timer_sequencer.sv
// Timer slot sequencer: an Avalon-MM master that reprograms the 16-bit interval
// timer from a table of one-shot periods, plus a host-facing Avalon-MM slave.
module nios2core_timer_sequencer #(
    parameter int unsigned SLOT_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // host slave
    input  logic [2:0]           s_address,
    input  logic                 s_chipselect,
    input  logic                 s_write_n,
    input  logic [31:0]          s_writedata,
    output logic [31:0]          s_readdata,
    output logic                 irq,
    // timer master
    output logic [2:0]           tm_address,
    output logic                 tm_chipselect,
    output logic                 tm_write_n,
    output logic [15:0]          tm_writedata,
    input  logic                 tm_irq,
    // slot completion
    output logic                 slot_event,
    output logic [SLOT_BITS-1:0] slot_index
);

    localparam int unsigned NUM_SLOTS = 1 << SLOT_BITS;
    localparam int unsigned LAST_LSB  = 4;
    localparam int unsigned LAST_MSB  = SLOT_BITS + 3;

    // host register map
    localparam logic [2:0] HOST_CTRL   = 3'd0;
    localparam logic [2:0] HOST_STATUS = 3'd1;

    // timer register map and command words
    localparam logic [2:0]  TM_REG_STATUS  = 3'd0;
    localparam logic [2:0]  TM_REG_CONTROL = 3'd1;
    localparam logic [2:0]  TM_REG_PERIODL = 3'd2;
    localparam logic [2:0]  TM_REG_PERIODH = 3'd3;
    localparam logic [15:0] TM_WORD_STOP   = 16'h0008;
    localparam logic [15:0] TM_WORD_START  = 16'h0005;
    localparam logic [15:0] TM_WORD_CLEAR  = 16'h0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_STOP,
        S_CLR,
        S_LDL,
        S_LDH,
        S_START,
        S_WAIT,
        S_ACK,
        S_GAP,
        S_ABORT_STOP,
        S_ABORT_CLR
    } state_e;

    state_e                state_q, state_d;

    // host-visible state
    logic                  run_q;
    logic                  loop_q;
    logic                  irq_en_q;
    logic [SLOT_BITS-1:0]  last_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [SLOT_BITS-1:0]  cur_q, cur_d;
    logic [31:0]           slot_q [NUM_SLOTS];
    logic [31:0]           readdata_q;

    // registered timer bus and slot outputs
    logic [2:0]            tm_address_q, tm_address_d;
    logic                  tm_chipselect_q, tm_chipselect_d;
    logic                  tm_write_n_q, tm_write_n_d;
    logic [15:0]           tm_writedata_q, tm_writedata_d;
    logic                  slot_event_q, slot_event_d;
    logic [SLOT_BITS-1:0]  slot_index_q, slot_index_d;

    // host decode
    logic                  host_wr_c;
    logic                  host_rd_c;
    logic                  ctrl_wr_c;
    logic                  status_wr_c;
    logic                  slot_hit_c;
    logic                  slot_wr_c;
    logic [SLOT_BITS-1:0]  slot_sel_c;
    logic                  abort_c;
    logic [31:0]           rd_c;
    logic [31:0]           cur_period_c;
    logic [15:0]           period_lo_c;

    // Decode host accesses; a CTRL write clearing run while busy is an abort.
    always_comb begin
        host_wr_c   = s_chipselect && !s_write_n;
        host_rd_c   = s_chipselect && s_write_n;
        ctrl_wr_c   = host_wr_c && (s_address == HOST_CTRL);
        status_wr_c = host_wr_c && (s_address == HOST_STATUS);
        slot_hit_c  = s_address[2] && (32'(s_address[1:0]) < NUM_SLOTS);
        slot_wr_c   = host_wr_c && slot_hit_c;
        slot_sel_c  = SLOT_BITS'(s_address[1:0]);
        abort_c     = ctrl_wr_c && !s_writedata[0] && busy_q;
    end

    // Live period of the current slot; a zero period is loaded as one.
    always_comb begin
        cur_period_c = slot_q[cur_q];
        period_lo_c  = (cur_period_c == 32'd0) ? 16'd1 : cur_period_c[15:0];
    end

    // Host read mux; unmapped addresses read as zero.
    always_comb begin
        rd_c = '0;
        case (s_address)
            HOST_CTRL: begin
                rd_c[0]                 = run_q;
                rd_c[1]                 = loop_q;
                rd_c[2]                 = irq_en_q;
                rd_c[LAST_MSB:LAST_LSB] = last_q;
            end
            HOST_STATUS: begin
                rd_c[0]                 = busy_q;
                rd_c[1]                 = done_q;
                rd_c[LAST_MSB:LAST_LSB] = cur_q;
            end
            default: begin
                if (slot_hit_c) begin
                    rd_c = slot_q[slot_sel_c];
                end
            end
        endcase
    end

    // Registered read data, updated on each host read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (host_rd_c) begin
            readdata_q <= rd_c;
        end
    end

    // CTRL register; every CTRL write updates all fields, the FSM decides what it means.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            last_q   <= '0;
        end else if (ctrl_wr_c) begin
            run_q    <= s_writedata[0];
            loop_q   <= s_writedata[1];
            irq_en_q <= s_writedata[2];
            last_q   <= s_writedata[LAST_MSB:LAST_LSB];
        end
    end

    // Period table; writable at any time, read live by the load states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (slot_wr_c) begin
            slot_q[slot_sel_c] <= s_writedata;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            cur_q           <= '0;
            tm_address_q    <= '0;
            tm_chipselect_q <= 1'b0;
            tm_write_n_q    <= 1'b1;
            tm_writedata_q  <= '0;
            slot_event_q    <= 1'b0;
            slot_index_q    <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            cur_q           <= cur_d;
            tm_address_q    <= tm_address_d;
            tm_chipselect_q <= tm_chipselect_d;
            tm_write_n_q    <= tm_write_n_d;
            tm_writedata_q  <= tm_writedata_d;
            slot_event_q    <= slot_event_d;
            slot_index_q    <= slot_index_d;
        end
    end

    // Next state, status updates and the single timer write issued per state.
    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q;
        done_d          = done_q;
        cur_d           = cur_q;
        tm_address_d    = '0;
        tm_chipselect_d = 1'b0;
        tm_write_n_d    = 1'b1;
        tm_writedata_d  = '0;
        slot_event_d    = 1'b0;
        slot_index_d    = slot_index_q;

        // a STATUS write clears done; a done set in GAP below overrides it
        if (status_wr_c) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_wr_c && s_writedata[0]) begin
                    cur_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_CONTROL;
                tm_writedata_d  = TM_WORD_STOP;
                state_d         = S_CLR;
            end
            S_CLR: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_STATUS;
                tm_writedata_d  = TM_WORD_CLEAR;
                state_d         = S_LDL;
            end
            S_LDL: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_PERIODL;
                tm_writedata_d  = period_lo_c;
                state_d         = S_LDH;
            end
            S_LDH: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_PERIODH;
                tm_writedata_d  = cur_period_c[31:16];
                state_d         = S_START;
            end
            S_START: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_CONTROL;
                tm_writedata_d  = TM_WORD_START;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                if (tm_irq) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_STATUS;
                tm_writedata_d  = TM_WORD_CLEAR;
                slot_event_d    = 1'b1;
                slot_index_d    = cur_q;
                state_d         = S_GAP;
            end
            S_GAP: begin
                // bus stays idle this cycle so the timer irq has dropped before the next load
                if (!abort_c) begin
                    if (cur_q != last_q) begin
                        cur_d   = cur_q + SLOT_BITS'(1);
                        state_d = S_LDL;
                    end else if (loop_q) begin
                        cur_d   = '0;
                        state_d = S_LDL;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ABORT_STOP: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_CONTROL;
                tm_writedata_d  = TM_WORD_STOP;
                state_d         = S_ABORT_CLR;
            end
            S_ABORT_CLR: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = TM_REG_STATUS;
                tm_writedata_d  = TM_WORD_CLEAR;
                busy_d          = 1'b0;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort: the current state's write still completes, then the timer is shut down
        if (abort_c && (state_q inside {S_STOP, S_CLR, S_LDL, S_LDH, S_START,
                                        S_WAIT, S_ACK, S_GAP})) begin
            state_d = S_ABORT_STOP;
        end
    end

    assign s_readdata    = readdata_q;
    assign irq           = done_q && irq_en_q;
    assign tm_address    = tm_address_q;
    assign tm_chipselect = tm_chipselect_q;
    assign tm_write_n    = tm_write_n_q;
    assign tm_writedata  = tm_writedata_q;
    assign slot_event    = slot_event_q;
    assign slot_index    = slot_index_q;

endmodule

// File: tb/tb_nios2core_timer_sequencer.sv
// Self-checking bench for the timer slot sequencer: a transaction-level model
// predicts the ordered timer writes and slot events from the slot table.
module tb_nios2core_timer_sequencer;

    localparam int unsigned SLOT_BITS = 2;
    localparam int unsigned NUM_SLOTS = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [2:0]           s_address;
    logic                 s_chipselect;
    logic                 s_write_n;
    logic [31:0]          s_writedata;
    logic [31:0]          s_readdata;
    logic                 irq;
    logic [2:0]           tm_address;
    logic                 tm_chipselect;
    logic                 tm_write_n;
    logic [15:0]          tm_writedata;
    logic                 tm_irq = 1'b0;
    logic                 slot_event;
    logic [SLOT_BITS-1:0] slot_index;

    nios2core_timer_sequencer #(.SLOT_BITS(SLOT_BITS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .irq           (irq),
        .tm_address    (tm_address),
        .tm_chipselect (tm_chipselect),
        .tm_write_n    (tm_write_n),
        .tm_writedata  (tm_writedata),
        .tm_irq        (tm_irq),
        .slot_event    (slot_event),
        .slot_index    (slot_index)
    );

    always #5 clk = ~clk;

    // model state
    logic [31:0] slot_m [NUM_SLOTS];
    logic [18:0] exp_wr_q [$];
    int          exp_ev_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b1;
    int          fires_left = 1000;
    bit          tm_armed = 1'b0;
    int          tm_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus monitor plus abstract timer: fires a few cycles after START, drops irq on a status clear.
    task automatic monitor_loop();
        logic [18:0] e;
        int          ei;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tm_irq   = 1'b0;
                tm_armed = 1'b0;
            end else begin
                if (tm_armed) begin
                    if (tm_cnt == 0) begin
                        tm_irq   = 1'b1;
                        tm_armed = 1'b0;
                    end else begin
                        tm_cnt--;
                    end
                end
                if (tm_chipselect && !tm_write_n) begin
                    if (tm_address == 3'd0) tm_irq = 1'b0;
                    if (tm_address == 3'd1 && tm_writedata == 16'h0008) tm_armed = 1'b0;
                    if (tm_address == 3'd1 && tm_writedata == 16'h0005 && fires_left > 0) begin
                        tm_armed = 1'b1;
                        tm_cnt   = $urandom_range(1, 5);
                        fires_left--;
                    end
                    if (mon_en) begin
                        if (exp_wr_q.size() == 0) begin
                            check_eq("tm_extra_write", {13'b0, tm_address, tm_writedata}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_wr_q.pop_front();
                            check_eq("tm_write", {13'b0, tm_address, tm_writedata}, {13'b0, e});
                        end
                    end
                end
                if (slot_event && mon_en) begin
                    if (exp_ev_q.size() == 0) begin
                        check_eq("slot_extra_event", 32'(slot_index), 32'hFFFF_FFFF);
                    end else begin
                        ei = exp_ev_q.pop_front();
                        check_eq("slot_index", 32'(slot_index), 32'(ei));
                    end
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        if (a >= 3'd4) slot_m[a - 3'd4] = d;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [31:0] d);
        s_address    = a;
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        d            = s_readdata;
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        exp_wr_q.push_back({a, d});
    endtask

    task automatic push_stop_clear();
        push_wr(3'd1, 16'h0008);
        push_wr(3'd0, 16'h0000);
    endtask

    // one slot: load period (0 becomes 1), start, then acknowledge the timeout
    task automatic push_load(input int n);
        logic [31:0] p;
        p = slot_m[n];
        push_wr(3'd2, (p == 32'd0) ? 16'd1 : p[15:0]);
        push_wr(3'd3, p[31:16]);
        push_wr(3'd1, 16'h0005);
    endtask

    task automatic push_ack(input int n);
        push_wr(3'd0, 16'h0000);
        exp_ev_q.push_back(n);
    endtask

    task automatic wait_empty(input string tag);
        int k;
        k = 0;
        while ((exp_wr_q.size() != 0 || exp_ev_q.size() != 0) && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_wr_q.size() != 0 || exp_ev_q.size() != 0) begin
            check_eq(tag, 32'(exp_wr_q.size() + exp_ev_q.size()), 32'd0);
            exp_wr_q.delete();
            exp_ev_q.delete();
        end
    endtask

    // non-looping run over slots 0..last, then done/irq and its clearing
    task automatic run_seq(input int last, input bit irq_en);
        logic [31:0] rd;
        push_stop_clear();
        for (int n = 0; n <= last; n++) begin
            push_load(n);
            push_ack(n);
        end
        host_write(3'd0, (32'(last) << 4) | (32'(irq_en) << 2) | 32'd1);
        wait_empty("run_timeout");
        wait_cycles(2);
        host_read(3'd1, rd);
        check_eq("status_done", rd, (32'(last) << 4) | 32'd2);
        check_eq("irq_done", 32'(irq), 32'(irq_en));
        host_write(3'd1, 32'd0);
        check_eq("irq_cleared", 32'(irq), 32'd0);
        host_read(3'd1, rd);
        check_eq("status_cleared", rd, 32'(last) << 4);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        int          k;
        bit          hit;
        int          last_r;

        reset_n      = 1'b0;
        s_address    = '0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) slot_m[i] = '0;
        fork
            monitor_loop();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_eq("rst_tm_write_n", 32'(tm_write_n), 32'd1);
        check_eq("rst_tm_cs", 32'(tm_chipselect), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_slot_event", 32'(slot_event), 32'd0);
        for (int a = 0; a < 8; a++) begin
            host_read(3'(a), rd);
            check_eq("rst_read", rd, 32'd0);
        end

        // register readback with random data
        for (int i = 0; i < NUM_SLOTS; i++) host_write(3'(4 + i), $urandom);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            host_read(3'(4 + i), rd);
            check_eq("slot_readback", rd, slot_m[i]);
        end
        w = $urandom & ~32'd1;
        host_write(3'd0, w);
        host_read(3'd0, rd);
        check_eq("ctrl_readback", rd, w & (32'h7 | (32'((1 << SLOT_BITS) - 1) << 4)));
        host_read(3'd2, rd);
        check_eq("unmapped_2", rd, 32'd0);
        host_read(3'd3, rd);
        check_eq("unmapped_3", rd, 32'd0);

        // single slot with interrupt
        host_write(3'd4, 32'h0000_0010);
        run_seq(0, 1'b1);

        // four slots including a zero period and a high half
        host_write(3'd4, 32'h0000_0010);
        host_write(3'd5, 32'h0000_0020);
        host_write(3'd6, 32'h0000_0000);
        host_write(3'd7, 32'h0001_0002);
        run_seq(3, 1'b0);

        // randomized tables and run lengths
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                host_write(3'(4 + i), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end
            last_r = $urandom_range(0, NUM_SLOTS - 1);
            run_seq(last_r, 1'($urandom_range(0, 1)));
        end

        // looping over slots 0..1, then abort while waiting on the timer
        fires_left = 5;
        push_stop_clear();
        for (int n = 0; n < 5; n++) begin
            push_load(n % 2);
            push_ack(n % 2);
        end
        push_load(1);
        host_write(3'd0, 32'h0000_0013);
        wait_empty("loop_timeout");
        wait_cycles(2);
        host_read(3'd1, rd);
        check_eq("loop_status", rd, 32'h0000_0011);
        push_stop_clear();
        host_write(3'd0, 32'h0000_0012);
        wait_empty("abort_timeout");
        wait_cycles(3);
        host_read(3'd1, rd);
        check_eq("abort_status", rd, 32'h0000_0010);
        wait_cycles(20);
        fires_left = 1000;

        // abort coinciding with the ACK cycle
        push_stop_clear();
        push_load(0);
        push_ack(0);
        push_stop_clear();
        host_write(3'd0, 32'h0000_0011);
        hit = 1'b0;
        k = 0;
        while (!hit && k < 200) begin
            @(posedge clk);
            hit = tm_irq;
            k++;
        end
        #1;
        check_eq("ack_irq_seen", 32'(hit), 32'd1);
        host_write(3'd0, 32'h0000_0010);
        wait_empty("ack_abort_timeout");
        wait_cycles(3);
        host_read(3'd1, rd);
        check_eq("ack_abort_status", rd, 32'h0000_0000);
        check_eq("ack_abort_irq", 32'(irq), 32'd0);

        // asynchronous reset while the high half is being loaded
        mon_en = 1'b0;
        host_write(3'd0, 32'h0000_0001);
        hit = 1'b0;
        k = 0;
        while (!hit && k < 100) begin
            @(negedge clk);
            hit = tm_chipselect && !tm_write_n && (tm_address == 3'd2);
            k++;
        end
        check_eq("ldh_reached", 32'(hit), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_tm_cs", 32'(tm_chipselect), 32'd0);
        check_eq("arst_tm_write_n", 32'(tm_write_n), 32'd1);
        check_eq("arst_tm_address", 32'(tm_address), 32'd0);
        check_eq("arst_tm_writedata", 32'(tm_writedata), 32'd0);
        check_eq("arst_slot_event", 32'(slot_event), 32'd0);
        check_eq("arst_readdata", s_readdata, 32'd0);
        exp_wr_q.delete();
        exp_ev_q.delete();
        for (int i = 0; i < NUM_SLOTS; i++) slot_m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        wait_cycles(1);
        host_read(3'd0, rd);
        check_eq("arst_ctrl", rd, 32'd0);
        host_read(3'd1, rd);
        check_eq("arst_status", rd, 32'd0);
        host_read(3'd4, rd);
        check_eq("arst_slot0", rd, slot_m[0]);
        wait_cycles(10);
        check_eq("arst_bus_idle", 32'(tm_chipselect), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
